// File: rtl/debounce_edge.sv
// Synchronises an asynchronous level, accepts a new level only after it has been
// seen on STABLE_CYCLES consecutive synchronised samples, and flags accepted edges.
`timescale 1ps/1ps

module debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic CLK,
    input  logic res,
    input  logic D_raw,
    output logic Q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_q_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    // Two-flop synchroniser; only r_s2 is allowed to reach the qualifier.
    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= D_raw;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (r_s2) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = LP_CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!r_s2) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_CNT_MAX) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!r_s2) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = LP_CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (r_s2) begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_CNT_MAX) begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + LP_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign Q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    // Decoded from the state register only, so D_raw never reaches an output combinationally.
    assign busy = (r_state == WAIT_HI) || (r_state == WAIT_LO);

    a_pulses_exclusive: assert property (@(posedge CLK) disable iff (res) !(rise && fall));
    a_cnt_in_range:     assert property (@(posedge CLK) disable iff (res) r_cnt <= LP_CNT_MAX);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed bench for debounce_edge: per-edge vector table plus reset corner sequences.
`timescale 1ps/1ps

module tb_debounce_edge;

    logic CLK;
    logic res;
    logic D_raw;
    logic Q;
    logic rise;
    logic fall;
    logic busy;

    int n_cmp;
    int n_err;

    // Expected outputs packed as {Q, rise, fall, busy}.
    logic [3:0] exp_q[$];

    typedef struct {
        logic       d;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[39];

    debounce_edge #(
        .STABLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .CLK(CLK),
        .res(res),
        .D_raw(D_raw),
        .Q(Q),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    initial CLK = 1'b0;
    always #50 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [3:0] got);
        logic [3:0] want;
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: {Q,rise,fall,busy} got %b required %b", name, got, want);
        end
    endtask

    // Drive D_raw, wait for the next rising edge, sample 10 ps later.
    task automatic step(input string name, input logic d, input logic [3:0] exp);
        D_raw = d;
        exp_q.push_back(exp);
        @(posedge CLK);
        #10;
        check(name, {Q, rise, fall, busy});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // clean rise, then glitch low for two samples
        vecs[ 0] = '{1'b1, 4'b0000};
        vecs[ 1] = '{1'b1, 4'b0000};
        vecs[ 2] = '{1'b1, 4'b0001};
        vecs[ 3] = '{1'b1, 4'b0001};
        vecs[ 4] = '{1'b1, 4'b0001};
        vecs[ 5] = '{1'b1, 4'b1100};
        vecs[ 6] = '{1'b1, 4'b1000};
        vecs[ 7] = '{1'b1, 4'b1000};
        vecs[ 8] = '{1'b0, 4'b1000};
        vecs[ 9] = '{1'b0, 4'b1000};
        vecs[10] = '{1'b1, 4'b1001};
        vecs[11] = '{1'b1, 4'b1001};
        vecs[12] = '{1'b1, 4'b1000};
        vecs[13] = '{1'b1, 4'b1000};
        // clean fall
        vecs[14] = '{1'b0, 4'b1000};
        vecs[15] = '{1'b0, 4'b1000};
        vecs[16] = '{1'b0, 4'b1001};
        vecs[17] = '{1'b0, 4'b1001};
        vecs[18] = '{1'b0, 4'b1001};
        vecs[19] = '{1'b0, 4'b0010};
        vecs[20] = '{1'b0, 4'b0000};
        // high for exactly 3 cycles: rejected
        vecs[21] = '{1'b1, 4'b0000};
        vecs[22] = '{1'b1, 4'b0000};
        vecs[23] = '{1'b1, 4'b0001};
        vecs[24] = '{1'b0, 4'b0001};
        vecs[25] = '{1'b0, 4'b0001};
        vecs[26] = '{1'b0, 4'b0000};
        vecs[27] = '{1'b0, 4'b0000};
        // high for exactly 4 cycles: accepted, then fall 6 edges after the return to 0
        vecs[28] = '{1'b1, 4'b0000};
        vecs[29] = '{1'b1, 4'b0000};
        vecs[30] = '{1'b1, 4'b0001};
        vecs[31] = '{1'b1, 4'b0001};
        vecs[32] = '{1'b0, 4'b0001};
        vecs[33] = '{1'b0, 4'b1100};
        vecs[34] = '{1'b0, 4'b1001};
        vecs[35] = '{1'b0, 4'b1001};
        vecs[36] = '{1'b0, 4'b1001};
        vecs[37] = '{1'b0, 4'b0010};
        vecs[38] = '{1'b0, 4'b0000};

        // reset clock and stimulus
        res   = 1'b0;
        D_raw = 1'b0;
        #10;
        res   = 1'b1;
        D_raw = 1'b1;
        #19;
        exp_q.push_back(4'b0000);
        check("reset_window", {Q, rise, fall, busy});
        #1;
        res   = 1'b0;
        D_raw = 1'b0;

        for (int i = 0; i < 39; i++) begin
            step($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp);
        end

        // reset asserted mid-qualification
        step("mq_e1", 1'b1, 4'b0000);
        step("mq_e2", 1'b1, 4'b0000);
        step("mq_e3", 1'b1, 4'b0001);
        step("mq_e4", 1'b1, 4'b0001);
        res = 1'b1;
        #1;
        exp_q.push_back(4'b0000);
        check("mq_async_reset", {Q, rise, fall, busy});
        @(posedge CLK);
        #10;
        exp_q.push_back(4'b0000);
        check("mq_reset_held", {Q, rise, fall, busy});
        #30;
        res = 1'b0;

        // D_raw still 1 at release: qualified from scratch
        step("rel_e1", 1'b1, 4'b0000);
        step("rel_e2", 1'b1, 4'b0000);
        step("rel_e3", 1'b1, 4'b0001);
        step("rel_e4", 1'b1, 4'b0001);
        step("rel_e5", 1'b1, 4'b0001);
        step("rel_e6", 1'b1, 4'b1100);
        step("rel_e7", 1'b1, 4'b1000);
        step("rel_e8", 1'b1, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
